dht_single_wire_reader: RTL and testbench
=========================================

Name: dht_single_wire_reader

Overview:
Parametrised single-wire humidity/temperature sensor reader covering the DHT11 and DHT22 families.
- Generates the host start pulse.
- Times the sensor response and decodes the 40-bit frame MSB-first.
- Verifies the checksum and flags timeouts.
- Presents one result per request over a start/done handshake to the system controller.
- The pad tristate lives at top level; this block sees only the sampled line and a drive-low enable.

Parameters:
CLK_HZ, 50000000, system clock frequency; derives the 1 us tick.
START_LOW_US, 18000, host start-pulse low time in us (DHT22 uses 1000).
TIMEOUT_US, 200, maximum time in us allowed in any wait-for-edge state.
BIT_THRESH_US, 50, high-phase length above which a data bit decodes as 1.
SYNC_STAGES, 2, input synchroniser depth, minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle read request; sampled only in IDLE
dq_in  in  1  raw line level from pad, asynchronous
dq_oe  out  1  1 = pull line low; 0 = release (pull-up)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transaction, success or error
valid  out  1  last transaction passed checksum; held until next accepted start
chk_err  out  1  checksum mismatch on last transaction; held
tmo_err  out  1  timeout on last transaction; held
hum_hi  out  8  frame byte 0
hum_lo  out  8  frame byte 1
tmp_hi  out  8  frame byte 2
tmp_lo  out  8  frame byte 3
chksum  out  8  frame byte 4

Behaviour:
- Reset (rst low, any state):
  - All outputs go to 0 and the state goes to IDLE.
  - dq_oe drops within the reset assertion, so the line is released even mid-operation.
- dq_in passes through a SYNC_STAGES flip-flop chain. Edges are detected on the synchronised value versus its one-cycle-delayed copy.
- A free-running prescaler produces us_tick every CLK_HZ/1000000 cycles.
- A 16-bit us counter clears on every state entry and increments on us_tick.
- IDLE: on start, accept the request.
  - Clear valid, chk_err and tmo_err; set busy; go to START.
  - start while busy is ignored.
- START: dq_oe=1 until count == START_LOW_US, then dq_oe=0 and go to WAIT_ACK.
- WAIT_ACK: on a falling edge go to ACK_LOW.
- ACK_LOW: on a rising edge go to ACK_HIGH.
- ACK_HIGH: on a falling edge, clear the bit index and go to BIT_LOW.
- BIT_LOW: on a rising edge go to BIT_HIGH.
- BIT_HIGH: on a falling edge, decode and advance.
  - The bit is 1 if count > BIT_THRESH_US, else 0.
  - Shift it into a 40-bit register, MSB first; byte 0 is bits 39:32.
  - Increment the bit index. If it reaches 40, go to CHECK; else go to BIT_LOW.
- Timeout:
  - In any of WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW or BIT_HIGH, count >= TIMEOUT_US goes to FINISH with tmo_err=1.
  - If a timeout and an edge occur in the same cycle, the timeout wins.
- CHECK, one cycle:
  - Compute the 8-bit sum of bytes 0..3, modulo 256.
  - On a match, set valid=1; else set chk_err=1.
  - Load the data outputs in either case; they are left unchanged on timeout.
- FINISH, one cycle: pulse done, clear busy, return to IDLE.
  - A start in the same cycle as done is ignored.
- Latency:
  - START phase is START_LOW_US*CLK_HZ/1e6 cycles, plus up to one tick of prescaler phase.
  - done follows the final falling edge by 2 cycles plus SYNC_STAGES.
- The block adds no minimum inter-read spacing; that is the controller's responsibility.

Decomposition:
- Package dht_pkg holds:
  - the state enum: IDLE, START, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK, FINISH;
  - FRAME_BITS=40;
  - a helper function us_to_cycles(CLK_HZ).
- One natural sub-module, dht_line_sync: the synchroniser plus rise/fall edge detector. The state machine, counters and checksum stay in the top.

Test Plan:
- Reset: hold rst low, then release → all outputs 0; dq_oe stays 0 while start is low.
- Good frame: CLK_HZ=1e6, START_LOW_US=18000; sensor model acks 80/80 us, then sends 0x37 0x00 0x19 0x00 0x50 with bit highs of 26/70 us → done after the frame; valid=1, hum_hi=0x37, tmp_hi=0x19, chksum=0x50, chk_err=0.
- Bad checksum: same frame with last byte 0x51 → chk_err=1, valid=0; data outputs still show 0x37/0x00/0x19/0x00/0x51.
- No sensor: line held high after release → tmo_err=1 and done 200 us after WAIT_ACK entry; data outputs unchanged from the prior read.
- Sensor stalls: line held low after bit 17 → tmo_err=1; busy drops; a following good frame then reads correctly.
- Protocol corner cases:
  - rst pulsed mid-BIT_HIGH → dq_oe=0 and busy=0 immediately.
  - start asserted while busy → ignored, exactly one done pulse.
  - DHT22 mode with START_LOW_US=1000 → dq_oe low for 1000 us.

Source files
------------

// File: rtl/dht_single_wire_reader_pkg.sv
// Shared types and helpers for the single-wire humidity/temperature reader.
//   dht_state_e   : reader FSM states
//   FRAME_BITS    : sensor frame length (4 data bytes + checksum)
//   us_to_cycles  : clock cycles per microsecond, never less than 1
package dht_pkg;

  localparam int FRAME_BITS = 40;

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_ACK,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    FINISH
  } dht_state_e;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz);
    return (clk_hz < 32'd1000000) ? 32'd1 : clk_hz / 32'd1000000;
  endfunction

endpackage

// File: rtl/dht_single_wire_reader_if.sv
// Request/result bus between the system controller and the reader.
//   start   : one-cycle read request (controller -> reader)
//   busy    : transaction in progress
//   done    : one-cycle end-of-transaction pulse
//   valid / chk_err / tmo_err : held status of the last transaction
//   hum_hi, hum_lo, tmp_hi, tmp_lo, chksum : frame bytes 0..4
interface dht_single_wire_reader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       valid;
  logic       chk_err;
  logic       tmo_err;
  logic [7:0] hum_hi;
  logic [7:0] hum_lo;
  logic [7:0] tmp_hi;
  logic [7:0] tmp_lo;
  logic [7:0] chksum;

  modport master (
    output start,
    input  busy, done, valid, chk_err, tmo_err,
    input  hum_hi, hum_lo, tmp_hi, tmp_lo, chksum
  );

  modport slave (
    input  start,
    output busy, done, valid, chk_err, tmo_err,
    output hum_hi, hum_lo, tmp_hi, tmp_lo, chksum
  );
endinterface

// File: rtl/dht_single_wire_reader_line_sync.sv
// Synchroniser and edge detector for the asynchronous sensor line.
//   clk, rst  : clock, asynchronous active-low reset
//   i_dq      : raw line level
//   o_rise    : synchronised line went 0 -> 1 this cycle
//   o_fall    : synchronised line went 1 -> 0 this cycle
module dht_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dq,
  output logic o_rise,
  output logic o_fall
);

  // Reset to 1: the idle line is pulled up, so no spurious edge after reset.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_dq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise =  w_lvl & ~r_prev;
  assign o_fall = ~w_lvl &  r_prev;

endmodule

// File: rtl/dht_single_wire_reader.sv
// Single-wire DHT11/DHT22 reader: start pulse, response timing, 40-bit
// MSB-first frame decode, checksum check and timeout detection.
//   clk, rst  : clock, asynchronous active-low reset
//   i_dq_in   : raw line level from the pad
//   o_dq_oe   : 1 = pull line low, 0 = release
//   bus       : controller request/result bus (slave side)
module dht_single_wire_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int          START_LOW_US  = 18000,
  parameter int          TIMEOUT_US    = 200,
  parameter int          BIT_THRESH_US = 50,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_dq_in,
  output logic                      o_dq_oe,
  dht_single_wire_reader_if.slave   bus
);

  localparam int unsigned DIV = us_to_cycles(CLK_HZ);
  localparam int          PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [15:0] C_START  = 16'(START_LOW_US);
  localparam logic [15:0] C_TMO    = 16'(TIMEOUT_US);
  localparam logic [15:0] C_THRESH = 16'(BIT_THRESH_US);
  localparam logic [5:0]  C_LAST   = 6'(FRAME_BITS - 1);

  dht_state_e r_state, w_state_d;

  logic [PW-1:0]         r_pre;
  logic                  w_tick;
  logic [15:0]           r_cnt;
  logic [5:0]            r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_data;
  logic                  r_oe, r_busy, r_done, r_valid, r_chk, r_tmo;

  logic w_rise, w_fall;
  logic w_accept, w_tmo, w_bit_ev, w_clr_idx, w_waiting;
  logic w_bit;
  logic [7:0] w_sum;
  logic       w_sum_ok;

  dht_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_dq   (i_dq_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Free-running microsecond prescaler.
  assign w_tick = (r_pre == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  // Next state and per-cycle actions.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_tmo     = 1'b0;
    w_bit_ev  = 1'b0;
    w_clr_idx = 1'b0;
    w_waiting = 1'b0;
    unique case (r_state)
      IDLE:     if (bus.start) begin
                  w_accept  = 1'b1;
                  w_state_d = START;
                end
      START:    if (r_cnt == C_START) w_state_d = WAIT_ACK;
      WAIT_ACK: begin
                  w_waiting = 1'b1;
                  if (w_fall) w_state_d = ACK_LOW;
                end
      ACK_LOW:  begin
                  w_waiting = 1'b1;
                  if (w_rise) w_state_d = ACK_HIGH;
                end
      ACK_HIGH: begin
                  w_waiting = 1'b1;
                  if (w_fall) begin
                    w_clr_idx = 1'b1;
                    w_state_d = BIT_LOW;
                  end
                end
      BIT_LOW:  begin
                  w_waiting = 1'b1;
                  if (w_rise) w_state_d = BIT_HIGH;
                end
      BIT_HIGH: begin
                  w_waiting = 1'b1;
                  if (w_fall) begin
                    w_bit_ev  = 1'b1;
                    w_state_d = (r_idx == C_LAST) ? CHECK : BIT_LOW;
                  end
                end
      CHECK:    w_state_d = FINISH;
      FINISH:   w_state_d = IDLE;
      default:  w_state_d = IDLE;
    endcase
    // Timeout overrides any edge seen in the same cycle.
    if (w_waiting && (r_cnt >= C_TMO)) begin
      w_tmo     = 1'b1;
      w_bit_ev  = 1'b0;
      w_clr_idx = 1'b0;
      w_state_d = FINISH;
    end
  end

  // Microsecond counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_cnt <= '0;
    else if (w_state_d != r_state) r_cnt <= '0;
    else if (w_tick)               r_cnt <= r_cnt + 16'd1;
  end

  assign w_bit    = (r_cnt > C_THRESH);
  assign w_sum    = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
  assign w_sum_ok = (w_sum == r_shift[7:0]);

  // Frame shift register and bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (w_clr_idx) begin
      r_idx   <= '0;
    end else if (w_bit_ev) begin
      r_idx   <= r_idx + 6'd1;
      r_shift <= {r_shift[FRAME_BITS-2:0], w_bit};
    end
  end

  // Line drive, handshake and held results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_chk   <= 1'b0;
      r_tmo   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_oe   <= (w_state_d == START);
      r_done <= (w_state_d == FINISH);
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_valid <= 1'b0;
        r_chk   <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (r_state == FINISH) r_busy <= 1'b0;
      if (w_tmo)             r_tmo  <= 1'b1;
      if (r_state == CHECK) begin
        r_valid <= w_sum_ok;
        r_chk   <= ~w_sum_ok;
        r_data  <= r_shift;
      end
    end
  end

  assign o_dq_oe     = r_oe;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.valid   = r_valid;
  assign bus.chk_err = r_chk;
  assign bus.tmo_err = r_tmo;
  assign bus.hum_hi  = r_data[39:32];
  assign bus.hum_lo  = r_data[31:24];
  assign bus.tmp_hi  = r_data[23:16];
  assign bus.tmp_lo  = r_data[15:8];
  assign bus.chksum  = r_data[7:0];

endmodule

// File: tb/tb_dht_single_wire_reader.sv
`timescale 1ns/1ps
module tb_dht_single_wire_reader;

  // 1 MHz clock: one cycle per microsecond.
  logic clk = 1'b0;
  always #500 clk = ~clk;

  logic rst;
  logic sensor_low;
  logic oe0, oe1;
  wire  line;
  assign line = ~(oe0 | oe1 | sensor_low);

  dht_single_wire_reader_if bus();
  dht_single_wire_reader_if bus18();

  // DHT22-style instance for most tests; DHT11-style instance for the 18 ms case.
  dht_single_wire_reader #(.CLK_HZ(1000000), .START_LOW_US(1000), .TIMEOUT_US(200),
                           .BIT_THRESH_US(50), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .i_dq_in(line), .o_dq_oe(oe0), .bus(bus));

  dht_single_wire_reader #(.CLK_HZ(1000000), .START_LOW_US(18000), .TIMEOUT_US(200),
                           .BIT_THRESH_US(50), .SYNC_STAGES(2)) u_dut18 (
    .clk(clk), .rst(rst), .i_dq_in(line), .o_dq_oe(oe1), .bus(bus18));

  typedef struct packed {
    logic        v;
    logic        c;
    logic        t;
    logic [39:0] d;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];
  int n_chk = 0;
  int n_err = 0;
  int done0 = 0;
  int done1 = 0;
  int cyc = 0;
  int done_cyc0 = 0;
  int oe_fall_cyc = 0;

  localparam logic [39:0] F_GOOD = 40'h37_00_19_00_50;
  localparam logic [39:0] F_BAD  = 40'h37_00_19_00_51;
  localparam logic [39:0] F_G2   = 40'h02_8C_01_5F_EE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic cmp_resp(input string tag, input resp_t a, input resp_t e);
    chk({tag, "_valid"},   64'(a.v), 64'(e.v));
    chk({tag, "_chk_err"}, 64'(a.c), 64'(e.c));
    chk({tag, "_tmo_err"}, 64'(a.t), 64'(e.t));
    chk({tag, "_data"},    64'(a.d), 64'(e.d));
  endtask

  // Monitor: pop and compare whenever either reader signals done.
  always @(negedge clk) begin
    resp_t a, e;
    if (bus.done) begin
      done0 <= done0 + 1;
      done_cyc0 <= cyc;
      a = {bus.valid, bus.chk_err, bus.tmo_err,
           bus.hum_hi, bus.hum_lo, bus.tmp_hi, bus.tmp_lo, bus.chksum};
      if (q0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL done0_unexpected got done with empty queue");
      end else begin
        e = q0.pop_front();
        cmp_resp("rd0", a, e);
      end
    end
    if (bus18.done) begin
      done1 <= done1 + 1;
      a = {bus18.valid, bus18.chk_err, bus18.tmo_err,
           bus18.hum_hi, bus18.hum_lo, bus18.tmp_hi, bus18.tmp_lo, bus18.chksum};
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL done1_unexpected got done with empty queue");
      end else begin
        e = q1.pop_front();
        cmp_resp("rd1", a, e);
      end
    end
  end

  function automatic logic oe_of(input int sel);
    return (sel != 0) ? oe1 : oe0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sensor model. mode: 0 normal, 1 stall low at bit nbit, 2 no sensor,
  // 3 reset pulse during high of bit nbit, 4 extra start during bit nbit.
  task automatic sensor(input int sel, input logic [39:0] f, input int mode,
                        input int nbit, input int exp_low);
    int t;
    int len;
    t = 0;
    len = 0;
    while (!oe_of(sel) && t < 10) begin @(negedge clk); t++; end
    chk("oe_rise", 64'(oe_of(sel)), 64'd1);
    if (!oe_of(sel)) return;
    while (oe_of(sel) && len < exp_low + 20) begin @(negedge clk); len++; end
    chk_rng("oe_low_len", len, exp_low - 2, exp_low + 2);
    oe_fall_cyc = cyc;
    if (mode == 2) return;
    wait_cyc(30);
    sensor_low = 1'b1; wait_cyc(80);
    sensor_low = 1'b0; wait_cyc(80);
    for (int i = 0; i < 40; i++) begin
      if (mode == 1 && i == nbit) begin
        sensor_low = 1'b1; wait_cyc(300);
        sensor_low = 1'b0;
        return;
      end
      sensor_low = 1'b1; wait_cyc(50);
      sensor_low = 1'b0;
      if (mode == 3 && i == nbit) begin
        wait_cyc(10);
        rst = 1'b0;
        #1;
        chk("rst_mid_oe",   64'(oe0), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        wait_cyc(3);
        rst = 1'b1;
        return;
      end
      if (mode == 4 && i == nbit) begin
        bus.start = 1'b1; @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(f[39-i] ? 69 : 25);
      end else begin
        wait_cyc(f[39-i] ? 70 : 26);
      end
    end
    sensor_low = 1'b1; wait_cyc(50);
    sensor_low = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int target);
    int t;
    t = 0;
    while (((sel != 0) ? done1 : done0) < target && t < 30000) begin
      @(negedge clk); t++;
    end
    chk("done_seen", 64'((sel != 0) ? done1 : done0), 64'(target));
    @(negedge clk);
    chk("busy_clr", 64'((sel != 0) ? bus18.busy : bus.busy), 64'd0);
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel != 0) bus18.start = 1'b1; else bus.start = 1'b1;
    @(negedge clk);
    bus18.start = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic read0(input logic [39:0] f, input int mode, input int nbit, input resp_t e);
    int target;
    target = done0 + 1;
    q0.push_back(e);
    pulse_start(0);
    sensor(0, f, mode, nbit, 1000);
    wait_done(0, target);
  endtask

  initial begin
    int base;
    rst = 1'b0;
    sensor_low = 1'b0;
    bus.start = 1'b0;
    bus18.start = 1'b0;

    // Reset state
    wait_cyc(5);
    chk("rst_oe",    64'(oe0 | oe1), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_flags", 64'({bus.valid, bus.chk_err, bus.tmo_err}), 64'd0);
    chk("rst_data",  64'({bus.hum_hi, bus.hum_lo, bus.tmp_hi, bus.tmp_lo, bus.chksum}), 64'd0);
    rst = 1'b1;
    wait_cyc(20);
    chk("idle_oe", 64'(oe0 | oe1), 64'd0);

    // DHT11 timing: 18 ms start pulse, good frame
    q1.push_back('{v:1'b1, c:1'b0, t:1'b0, d:F_GOOD});
    pulse_start(1);
    sensor(1, F_GOOD, 0, 0, 18000);
    wait_done(1, 1);

    // DHT22 timing: good frame, bad checksum
    read0(F_GOOD, 0, 0, '{v:1'b1, c:1'b0, t:1'b0, d:F_GOOD});
    read0(F_BAD,  0, 0, '{v:1'b0, c:1'b1, t:1'b0, d:F_BAD});

    // No sensor: timeout, data kept from the previous read
    read0(F_GOOD, 2, 0, '{v:1'b0, c:1'b0, t:1'b1, d:F_BAD});
    chk_rng("tmo_latency", done_cyc0 - oe_fall_cyc, 198, 204);

    // Sensor stalls low at bit 17, then a good frame recovers
    read0(F_GOOD, 1, 17, '{v:1'b0, c:1'b0, t:1'b1, d:F_BAD});
    read0(F_G2,   0, 0,  '{v:1'b1, c:1'b0, t:1'b0, d:F_G2});

    // Extra start while busy: ignored, exactly one done
    base = done0;
    read0(F_GOOD, 4, 5, '{v:1'b1, c:1'b0, t:1'b0, d:F_GOOD});
    wait_cyc(50);
    chk("one_done", 64'(done0), 64'(base + 1));
    chk("no_restart_oe", 64'(oe0), 64'd0);

    // Reset mid BIT_HIGH: no done expected, everything cleared
    base = done0;
    pulse_start(0);
    sensor(0, F_G2, 3, 9, 1000);
    wait_cyc(300);
    chk("rst_no_done", 64'(done0), 64'(base));
    chk("rst2_flags",  64'({bus.busy, bus.valid, bus.chk_err, bus.tmo_err}), 64'd0);
    chk("rst2_data",   64'({bus.hum_hi, bus.hum_lo, bus.tmp_hi, bus.tmp_lo, bus.chksum}), 64'd0);

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
